// File: rtl/nios2_cpu_div_pkg.sv
// Shared types and constants for the NIOS2 A-stage iterative divider.
// Restoring radix-2: one quotient bit per clock.
package nios2_cpu_div_pkg;

  localparam int DIV_DATA_W  = 32;
  localparam int DIV_LATENCY = DIV_DATA_W + 3;
  localparam int DIV_CNT_W   = $clog2(DIV_DATA_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_CALC,
    S_FIX,
    S_DONE
  } div_state_e;

endpackage

// File: rtl/nios2_cpu_div_step.sv
// One restoring-division iteration: shift in the next dividend bit,
// trial-subtract the divisor, keep the difference if non-negative.
module nios2_cpu_div_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] i_rem,
  input  logic [DATA_W-1:0] i_q,
  input  logic [DATA_W-1:0] i_divisor,
  output logic [DATA_W-1:0] o_rem,
  output logic [DATA_W-1:0] o_q
);

  logic [DATA_W:0] w_rem_w;
  logic [DATA_W:0] w_trial;
  logic            w_neg;

  // rem can exceed 2^(W-1) for large unsigned divisors, so keep W+1 bits
  assign w_rem_w = {i_rem, i_q[DATA_W-1]};
  assign w_trial = w_rem_w - {1'b0, i_divisor};
  assign w_neg   = w_trial[DATA_W];

  always_comb begin
    o_rem = w_trial[DATA_W-1:0];
    if (w_neg) o_rem = w_rem_w[DATA_W-1:0];
    o_q = {i_q[DATA_W-2:0], ~w_neg};
  end

endmodule

// File: rtl/nios2_cpu_div_cell.sv
// NIOS2 A-stage divider: signed/unsigned, DATA_W+3 cycle latency,
// single-cycle done pulse, kill abandons work in flight.
import nios2_cpu_div_pkg::*;

module nios2_cpu_div_cell #(
  parameter int DATA_W = DIV_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] A_div_src1,
  input  logic [DATA_W-1:0] A_div_src2,
  input  logic              A_div_signed,
  input  logic              A_div_start,
  input  logic              A_div_kill,
  output logic              A_div_busy,
  output logic              A_div_done,
  output logic [DATA_W-1:0] A_div_cell_result,
  output logic [DATA_W-1:0] A_div_cell_rem,
  output logic              A_div_by_zero
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DATA_W - 1);

  div_state_e        r_state;
  logic [DATA_W-1:0] r_src1;
  logic [DATA_W-1:0] r_src2;
  logic              r_signed;
  logic [DATA_W-1:0] r_q;
  logic [DATA_W-1:0] r_rem;
  logic [DATA_W-1:0] r_div;
  logic              r_sign_q;
  logic              r_sign_r;
  logic              r_zero;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_busy;
  logic              r_done;
  logic [DATA_W-1:0] r_result;
  logic [DATA_W-1:0] r_rem_out;
  logic              r_by_zero;

  logic [DATA_W-1:0] w_rem;
  logic [DATA_W-1:0] w_q;
  logic              w_s1;
  logic              w_s2;

  assign w_s1 = r_signed & r_src1[DATA_W-1];
  assign w_s2 = r_signed & r_src2[DATA_W-1];

  nios2_cpu_div_step #(
    .DATA_W(DATA_W)
  ) u_step (
    .i_rem    (r_rem),
    .i_q      (r_q),
    .i_divisor(r_div),
    .o_rem    (w_rem),
    .o_q      (w_q)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_src1    <= '0;
      r_src2    <= '0;
      r_signed  <= 1'b0;
      r_q       <= '0;
      r_rem     <= '0;
      r_div     <= '0;
      r_sign_q  <= 1'b0;
      r_sign_r  <= 1'b0;
      r_zero    <= 1'b0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_result  <= '0;
      r_rem_out <= '0;
      r_by_zero <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (A_div_start && !A_div_kill) begin
            r_src1   <= A_div_src1;
            r_src2   <= A_div_src2;
            r_signed <= A_div_signed;
            r_busy   <= 1'b1;
            r_state  <= S_PREP;
          end
        end
        S_PREP: begin
          if (A_div_kill) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_q      <= w_s1 ? -r_src1 : r_src1;
            r_div    <= w_s2 ? -r_src2 : r_src2;
            r_rem    <= '0;
            r_sign_q <= w_s1 ^ w_s2;
            r_sign_r <= w_s1;
            r_zero   <= (r_src2 == '0);
            r_cnt    <= '0;
            r_state  <= S_CALC;
          end
        end
        S_CALC: begin
          if (A_div_kill) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_rem <= w_rem;
            r_q   <= w_q;
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CNT_MAX) r_state <= S_FIX;
          end
        end
        S_FIX: begin
          if (A_div_kill) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            // zero divisor reports the raw dividend, sign fixup bypassed
            if (r_zero) begin
              r_result  <= '1;
              r_rem_out <= r_src1;
            end else begin
              r_result  <= r_sign_q ? -r_q : r_q;
              r_rem_out <= r_sign_r ? -r_rem : r_rem;
            end
            r_by_zero <= r_zero;
            r_done    <= 1'b1;
            r_state   <= S_DONE;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign A_div_busy        = r_busy;
  assign A_div_done        = r_done;
  assign A_div_cell_result = r_result;
  assign A_div_cell_rem    = r_rem_out;
  assign A_div_by_zero     = r_by_zero;

endmodule

// File: tb/tb_nios2_cpu_div_cell.sv
// Directed + scoreboard bench for nios2_cpu_div_cell (DATA_W = 32).
// Expected results are queued at start and compared on done.
module tb_nios2_cpu_div_cell;

  localparam int W = 32;
  localparam int LAT = 35;
  localparam logic [W-1:0] MINV = 32'h8000_0000;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         bz;
  } exp_t;

  logic         clk;
  logic         reset;
  logic [W-1:0] A_div_src1;
  logic [W-1:0] A_div_src2;
  logic         A_div_signed;
  logic         A_div_start;
  logic         A_div_kill;
  logic         A_div_busy;
  logic         A_div_done;
  logic [W-1:0] A_div_cell_result;
  logic [W-1:0] A_div_cell_rem;
  logic         A_div_by_zero;

  exp_t sb[$];
  int   n_total;
  int   n_pass;

  nios2_cpu_div_cell #(.DATA_W(W)) dut (
    .clk              (clk),
    .reset            (reset),
    .A_div_src1       (A_div_src1),
    .A_div_src2       (A_div_src2),
    .A_div_signed     (A_div_signed),
    .A_div_start      (A_div_start),
    .A_div_kill       (A_div_kill),
    .A_div_busy       (A_div_busy),
    .A_div_done       (A_div_done),
    .A_div_cell_result(A_div_cell_result),
    .A_div_cell_rem   (A_div_cell_rem),
    .A_div_by_zero    (A_div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [64:0] obs,
                     input logic [64:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic exp_t model(input logic [W-1:0] a,
                                 input logic [W-1:0] b,
                                 input logic s);
    exp_t e;
    logic signed [W-1:0] sa, sbv;
    sa = a;
    sbv = b;
    if (b == '0) begin
      e.q = '1; e.r = a; e.bz = 1'b1;
    end else if (s && a == MINV && b == '1) begin
      e.q = MINV; e.r = '0; e.bz = 1'b0;
    end else if (s) begin
      e.q = sa / sbv; e.r = sa % sbv; e.bz = 1'b0;
    end else begin
      e.q = a / b; e.r = a % b; e.bz = 1'b0;
    end
    return e;
  endfunction

  function automatic logic [64:0] outs();
    return {A_div_cell_result, A_div_cell_rem, A_div_by_zero};
  endfunction

  // called at the negedge of the start cycle; returns at done's negedge
  task automatic wait_done(input int hold, output int lat,
                           output bit busy_ok);
    lat = 0;
    busy_ok = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k >= hold) A_div_start = 1'b0;
      if (!A_div_busy) busy_ok = 1'b0;
      if (A_div_done) begin
        lat = k;
        break;
      end
    end
    A_div_start = 1'b0;
  endtask

  task automatic check_done(input string tag);
    exp_t want;
    if (sb.size() > 0) begin
      want = sb.pop_front();
      chk(tag, outs(), want);
    end else begin
      chk({tag, "_sb_empty"}, 65'd0, 65'd1);
    end
  endtask

  task automatic do_op(input string tag, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic s,
                       input exp_t e, input int hold);
    int lat;
    bit bok;
    chk({tag, "_idle"}, 65'(A_div_busy), 65'd0);
    sb.push_back(e);
    A_div_src1 = a;
    A_div_src2 = b;
    A_div_signed = s;
    A_div_start = 1'b1;
    wait_done(hold, lat, bok);
    chk({tag, "_lat"}, 65'(lat), 65'(LAT));
    chk({tag, "_busy"}, 65'(bok), 65'd1);
    check_done(tag);
    @(negedge clk);
    chk({tag, "_pulse"}, 65'({A_div_done, A_div_busy}), 65'd0);
  endtask

  initial begin
    int lat;
    bit bok;
    bit no_done;
    logic [W-1:0] ra, rb;
    logic rs;
    n_total = 0;
    n_pass = 0;
    reset = 1'b1;
    A_div_src1 = '0;
    A_div_src2 = '0;
    A_div_signed = 1'b0;
    A_div_start = 1'b0;
    A_div_kill = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_state",
        {A_div_busy, A_div_done, A_div_cell_result, A_div_cell_rem,
         A_div_by_zero}, '0);
    reset = 1'b0;
    @(negedge clk);

    do_op("divu_100_7", 32'd100, 32'd7, 1'b0, {32'd14, 32'd2, 1'b0}, 1);
    do_op("div_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1,
          {32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0}, 1);
    do_op("div_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1,
          {32'hFFFF_FFFD, 32'd1, 1'b0}, 1);
    do_op("div_min_m1", MINV, 32'hFFFF_FFFF, 1'b1,
          {MINV, 32'd0, 1'b0}, 1);
    do_op("divu_max_1", 32'hFFFF_FFFF, 32'd1, 1'b0,
          {32'hFFFF_FFFF, 32'd0, 1'b0}, 1);
    do_op("divu_1234_0", 32'd1234, 32'd0, 1'b0,
          {32'hFFFF_FFFF, 32'd1234, 1'b1}, 1);
    do_op("div_m5_0", 32'hFFFF_FFFB, 32'd0, 1'b1,
          {32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1}, 1);
    do_op("divu_big_div", 32'hFFFF_FFFE, 32'hC000_0001, 1'b0,
          {32'd1, 32'h3FFF_FFFD, 1'b0}, 1);
    do_op("hold_start", 32'd1000, 32'd3, 1'b0, {32'd333, 32'd1, 1'b0}, 20);

    // kill+start together in IDLE must not launch
    A_div_start = 1'b1;
    A_div_kill = 1'b1;
    @(negedge clk);
    A_div_start = 1'b0;
    A_div_kill = 1'b0;
    chk("kill_start_idle", 65'(A_div_busy), 65'd0);

    // kill mid-CALC at cycle 10, restart at cycle 12
    A_div_src1 = 32'd55;
    A_div_src2 = 32'd5;
    A_div_signed = 1'b0;
    A_div_start = 1'b1;
    no_done = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      A_div_start = 1'b0;
      if (A_div_done) no_done = 1'b0;
    end
    A_div_kill = 1'b1;
    @(negedge clk);
    A_div_kill = 1'b0;
    chk("kill_busy_low", 65'(A_div_busy), 65'd0);
    chk("kill_keep", outs(), {32'd333, 32'd1, 1'b0});
    sb.push_back({32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b0});
    @(negedge clk);
    if (A_div_done) no_done = 1'b0;
    A_div_src1 = 32'hFFFF_FFF0;
    A_div_src2 = 32'd3;
    A_div_signed = 1'b1;
    A_div_start = 1'b1;
    wait_done(1, lat, bok);
    chk("kill_no_done", 65'(no_done), 65'd1);
    chk("restart_cycle", 65'(12 + lat), 65'd47);
    check_done("restart_result");
    @(negedge clk);

    // async reset in the middle of CALC
    A_div_src1 = 32'd999;
    A_div_src2 = 32'd4;
    A_div_signed = 1'b0;
    A_div_start = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      A_div_start = 1'b0;
    end
    #2 reset = 1'b1;
    #1;
    chk("async_reset",
        {A_div_busy, A_div_done, A_div_cell_result, A_div_cell_rem,
         A_div_by_zero}, '0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    do_op("post_reset", 32'd50, 32'd7, 1'b0, {32'd7, 32'd1, 1'b0}, 1);

    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = (i == 2) ? 32'd0 : ($urandom >> (i * 4));
      rs = i[0];
      do_op("rand", ra, rb, rs, model(ra, rb, rs), 1);
    end

    chk("sb_drained", 65'(sb.size()), 65'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
